// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file write side.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder5to32.sv
// Enabled 5-to-32 one-hot decoder; the inverse of the 32:1 read mux.
module decoder5to32
  import regfile_pkg::*;
(
  input  logic                 ena,
  input  reg_addr_t            in,
  output logic [REG_COUNT-1:0] out
);

  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    out = '0;
    if (ena) out[in] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32-entry register file with a per-register busy scoreboard.
// Register 0 is constant zero and never busy.
module regfile_write_bank
  import regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_ena,
  input  reg_addr_t              wr_addr,
  input  logic [N-1:0]           wr_data,
  input  logic                   rsv_ena,
  input  reg_addr_t              rsv_addr,
  output logic [REG_COUNT*N-1:0] regs_out,
  output logic [REG_COUNT-1:0]   busy,
  output logic [15:0]            wr_count
);

  logic [REG_COUNT-1:0] wr_sel;
  logic [REG_COUNT-1:0] rsv_sel;
  logic                 commit;
  logic                 unused_sel0;

  decoder5to32 u_wr_dec (
    .ena (wr_ena),
    .in  (wr_addr),
    .out (wr_sel)
  );

  decoder5to32 u_rsv_dec (
    .ena (rsv_ena),
    .in  (rsv_addr),
    .out (rsv_sel)
  );

  // Selecting register 0 is a legal no-op, so that decode line goes nowhere.
  assign unused_sel0 = wr_sel[0] | rsv_sel[0];
  assign commit      = |wr_sel[REG_COUNT-1:1];

  assign regs_out[0 +: N] = '0;
  assign busy[0]          = 1'b0;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    logic [N-1:0] q;
    logic         b;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst)            q <= '0;
      else if (wr_sel[i]) q <= wr_data;
    end

    // A reservation in the same cycle as the write-back belongs to a new producer, so it wins.
    always_ff @(posedge clk) begin
      if (rst)             b <= 1'b0;
      else if (rsv_sel[i]) b <= 1'b1;
      else if (wr_sel[i])  b <= 1'b0;
    end

    assign regs_out[i*N +: N] = q;
    assign busy[i]            = b;
  end

  always_ff @(posedge clk) begin
    if (rst)         wr_count <= '0;
    else if (commit) wr_count <= wr_count + 16'd1;
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed, table-driven self-checking bench for regfile_write_bank.
module tb_regfile_write_bank;

  localparam int N = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_ena;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic            rsv_ena;
  logic [4:0]      rsv_addr;
  logic [32*N-1:0] regs_out;
  logic [31:0]     busy;
  logic [15:0]     wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_bank #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_ena  (rsv_ena),
    .rsv_addr (rsv_addr),
    .regs_out (regs_out),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_ena;
    logic [4:0]  rsv_addr;
    int          chk_idx;
    logic [31:0] exp_reg;
    logic [31:0] exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic re, logic [4:0] ra, int idx, logic [31:0] er,
                              logic [31:0] eb, logic [15:0] ec);
    vec_t v;
    v.rst = r; v.wr_ena = we; v.wr_addr = wa; v.wr_data = wd;
    v.rsv_ena = re; v.rsv_addr = ra;
    v.chk_idx = idx; v.exp_reg = er; v.exp_busy = eb; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(int i);
    return regs_out[i*N +: N];
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra);
    rst = r; wr_ena = we; wr_addr = wa; wr_data = wd; rsv_ena = re; rsv_addr = ra;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[$];
  logic [31:0] model[32];

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rsv_ena = 1'b0; rsv_addr = '0;

    //            rst we  wa     wd            re  ra    idx exp_reg       exp_busy      cnt
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 5, 32'h0,        32'h0,        16'd0));
    vecs.push_back(mk(1, 1, 5'd5,  32'h1234,     1, 5'd5, 5, 32'h0,        32'h0,        16'd0));
    vecs.push_back(mk(0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 5, 32'hDEADBEEF, 32'h0,        16'd1));
    vecs.push_back(mk(0, 0, 5'd4,  32'hFFFFFFFF, 0, 5'd0, 4, 32'h0,        32'h0,        16'd1));
    vecs.push_back(mk(0, 0, 5'd6,  32'hFFFFFFFF, 0, 5'd0, 6, 32'h0,        32'h0,        16'd1));
    vecs.push_back(mk(0, 1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, 0, 32'h0,        32'h0,        16'd1));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0, 0, 32'h0,        32'h0,        16'd1));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7, 7, 32'h0,        32'h00000080, 16'd1));
    vecs.push_back(mk(0, 1, 5'd7,  32'h12,       0, 5'd0, 7, 32'h12,       32'h0,        16'd2));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd9, 9, 32'h0,        32'h00000200, 16'd2));
    vecs.push_back(mk(0, 1, 5'd9,  32'hA5,       1, 5'd9, 9, 32'hA5,       32'h00000200, 16'd3));
    vecs.push_back(mk(0, 1, 5'd9,  32'h5A,       1, 5'd3, 9, 32'h5A,       32'h00000008, 16'd4));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd3, 3, 32'h0,        32'h00000008, 16'd4));
    vecs.push_back(mk(0, 1, 5'd5,  32'h77,       0, 5'd0, 5, 32'h77,       32'h00000008, 16'd5));
    vecs.push_back(mk(0, 1, 5'd3,  32'h33,       0, 5'd0, 3, 32'h33,       32'h0,        16'd6));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 7, 32'h12,       32'h0,        16'd6));

    @(negedge clk);
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].wr_ena, vecs[k].wr_addr, vecs[k].wr_data,
            vecs[k].rsv_ena, vecs[k].rsv_addr);
      check($sformatf("vec%0d_reg%0d", k, vecs[k].chk_idx), reg_at(vecs[k].chk_idx), vecs[k].exp_reg);
      check($sformatf("vec%0d_busy", k), busy, vecs[k].exp_busy);
      check($sformatf("vec%0d_count", k), {16'h0, wr_count}, {16'h0, vecs[k].exp_cnt});
    end

    // Exhaustive one-hot decode from a clean reset.
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      model[i] = i * 32'h01010101;
      drive(0, 1, 5'(i), model[i], 0, 5'd0);
    end
    for (int i = 0; i < 32; i++) check($sformatf("decode_reg%0d", i), reg_at(i), model[i]);
    check("decode_count", {16'h0, wr_count}, 32'd31);
    check("decode_busy", busy, 32'h0);

    // Reserve everything, then reset with a write and reserve presented in the same cycle.
    for (int i = 0; i < 32; i++) drive(0, 0, 5'd0, 32'h0, 1, 5'(i));
    check("all_reserved", busy, 32'hFFFFFFFE);
    drive(1, 1, 5'd4, 32'hCAFEF00D, 1, 5'd4);
    for (int i = 0; i < 32; i++) check($sformatf("midrst_reg%0d", i), reg_at(i), 32'h0);
    check("midrst_busy", busy, 32'h0);
    check("midrst_count", {16'h0, wr_count}, 32'd0);

    // Counter wrap: 65535 committed writes reach FFFF, one more returns to 0.
    for (int i = 0; i < 65535; i++) drive(0, 1, 5'd1, 32'(i), 0, 5'd0);
    check("count_ffff", {16'h0, wr_count}, 32'h0000FFFF);
    check("wrap_reg1", reg_at(1), 32'd65534);
    drive(0, 1, 5'd2, 32'hBEEF, 0, 5'd0);
    check("count_wrap", {16'h0, wr_count}, 32'h0);
    check("wrap_reg2", reg_at(2), 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the 32-entry register file: decodes a 5-bit write address to one-hot and stores data into one of 32 N-bit registers.
- Exposes all 32 register values as one flat bus. That bus feeds the existing 32:1 read muxes, which are the read side.
- Includes a per-register busy scoreboard. Issue logic reserves a destination register and write-back clears the reservation.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- N, 32, data width of each register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wr_ena  input  1  write-back strobe.
- wr_addr  input  5  destination register index for write-back.
- wr_data  input  N  write-back data.
- rsv_ena  input  1  reserve strobe, driven from issue.
- rsv_addr  input  5  register index to mark busy.
- regs_out  output  32*N  flat register contents; register i occupies bits [i*N +: N].
- busy  output  32  scoreboard; bit i set means a write to register i is outstanding.
- wr_count  output  16  number of committed writes since reset, wrapping.

Behaviour:
- Reset:
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
  - While rst=1 at an edge: all registers go to 0, busy goes to 32'h0, wr_count goes to 0.
  - Reset overrides any wr_ena or rsv_ena in the same cycle. Nothing is written, nothing is reserved, nothing is counted.
- Write:
  - If wr_ena=1 and wr_addr!=0 at an edge, register[wr_addr] takes wr_data.
  - The new value appears on regs_out in the following cycle. Latency is 1, with no write-to-read bypass inside this block.
- Register 0:
  - wr_ena=1 with wr_addr=0 is a legal no-op. Register 0 stays 0, busy[0] stays 0, and wr_count does not increment.
- wr_count:
  - Increments by 1 for each committed write, meaning wr_ena=1 and wr_addr!=0.
  - Wraps from 16'hFFFF to 16'h0000.
- Write decode:
  - wr_addr is decoded to a one-hot 32-bit enable, gated by wr_ena.
  - Each register has an independent load enable. No other register changes on a write.
- Scoreboard:
  - rsv_ena=1 with rsv_addr!=0 sets busy[rsv_addr] at the edge.
  - A committed write clears busy[wr_addr] at the edge.
  - rsv_addr=0 is ignored.
- Simultaneous reserve and write, different addresses: both take effect in the same cycle.
- Simultaneous reserve and write, same address (nonzero):
  - The data write occurs.
  - busy ends up set, because the reservation is for a new producer.
- Reserve of an already-busy register: busy stays 1; there is no error and no counting.
- Write to a non-busy register: the data is written and busy stays 0. Writes are never blocked by the scoreboard.
- Reset in the middle of operation:
  - Any outstanding reservations are discarded.
  - A write presented in the reset cycle is lost.
- Unknown inputs: wr_addr and wr_data are don't-care when wr_ena=0. The implementation must not load any register in that case.

Decomposition:
- Shared package regfile_pkg holds:
  - constant REG_COUNT=32.
  - constant REG_ADDR_W=5.
  - typedef reg_addr_t, equal to logic [REG_ADDR_W-1:0].
- One sub-module, decoder5to32:
  - Purely combinational, the inverse of the 32:1 mux.
  - Inputs: ena, in[4:0]. Output: out[31:0], one-hot.
  - Output is all-zero when ena=0.
- regfile_write_bank instantiates decoder5to32 twice: once for the write path, once for the reserve path.
- The registers and scoreboard use a generate loop over indices 1..31. Index 0 is a constant.

Test Plan:
- Reset, then write x5 and check surrounding registers:
  - Hold rst=1 for 2 cycles, release, then write wr_addr=5, wr_data=32'hDEADBEEF.
  - Next cycle regs_out[5*32+:32]=32'hDEADBEEF; registers 4 and 6 read 0; wr_count=1.
- Writes to register 0 are ignored:
  - Write wr_addr=0, wr_data=32'hFFFFFFFF.
  - Register 0 still reads 0, busy[0]=0, wr_count unchanged.
- Reserve then retire:
  - rsv_addr=7 -> busy=32'h00000080 the next cycle.
  - Then write wr_addr=7, data=32'h12 -> busy=0 and register 7 reads 32'h12.
- Same-cycle reserve and write:
  - With busy[9]=1, present rsv_addr=9 and wr_addr=9 (data=32'hA5) together.
  - Register 9 reads 32'hA5 and busy[9] stays 1.
  - The same cycle pattern with rsv_addr=3, wr_addr=9 -> busy[3]=1 and busy[9]=0.
- Exhaustive one-hot decode:
  - For i=1..31, write i*32'h01010101.
  - Every register i holds its own value and no other register is disturbed.
  - wr_count=31.
- Reset mid-operation:
  - With busy=32'hFFFFFFFE and nonzero registers, assert rst with wr_ena=1, wr_addr=4 in the same cycle.
  - All registers read 0, busy=0, wr_count=0.
